// File: rtl/modem_axi_regs.sv
// AXI4-Lite slave: CPU write port into the TX ring dpram, read port out of the RX ring dpram, ring pointers.
// Optional: define MODEM_AXI_SLVERR_EN to answer unmapped/illegal accesses with SLVERR.
module modem_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 13
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [7:0]                      rx_wp_i,
    input  logic [7:0]                      tx_rp_i,
    output logic [7:0]                      rx_rp_o,
    output logic [7:0]                      tx_wp_o,
    output logic [31:0]                     tx_wdata_o,
    output logic [7:0]                      tx_waddr_o,
    output logic                            tx_wen_o,
    input  logic [31:0]                     rx_rdata_i,
    output logic [7:0]                      rx_raddr_o
);

    localparam logic [10:0] W_TX_WP = 11'h400;
    localparam logic [10:0] W_TX_RP = 11'h401;
    localparam logic [10:0] W_RX_WP = 11'h402;
    localparam logic [10:0] W_RX_RP = 11'h403;
    localparam logic [10:0] W_ID    = 11'h404;
    localparam logic [31:0] ID_VALUE = 32'h4D4F4445;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    // Word-address decode of the read mux; bits [10:8] of the word select the 1 KiB window.
    function automatic logic [31:0] rd_mux(input logic [10:0] word, input logic [31:0] rx_word,
                                           input logic [7:0] tx_wp, input logic [7:0] tx_rp,
                                           input logic [7:0] rx_wp, input logic [7:0] rx_rp);
        rd_mux = '0;
        if (word[10:8] == 3'b001) begin
            rd_mux = rx_word;
        end else begin
            case (word)
                W_TX_WP: rd_mux = {24'd0, tx_wp};
                W_TX_RP: rd_mux = {24'd0, tx_rp};
                W_RX_WP: rd_mux = {24'd0, rx_wp};
                W_RX_RP: rd_mux = {24'd0, rx_rp};
                W_ID:    rd_mux = ID_VALUE;
                default: rd_mux = '0;
            endcase
        end
    endfunction

    logic        aw_ready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic [7:0]  tx_wp_q;
    logic [7:0]  rx_rp_q;
    logic        wr_hs;
    logic        wr_tx_win;
    logic [10:0] wr_word;
    logic [1:0]  wr_resp;

    logic [1:0]  rd_state;
    logic        ar_ready_q;
    logic        ar_hs;
    logic [10:0] ar_word_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rvalid_q;
    logic [1:0]  rd_resp;

    assign wr_word   = S_AXI_AWADDR[12:2];
    assign wr_tx_win = (S_AXI_AWADDR[12:10] == 3'b000);
    assign wr_hs     = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign ar_hs     = ar_ready_q & S_AXI_ARVALID;

`ifdef MODEM_AXI_SLVERR_EN
    assign wr_resp = (wr_tx_win || wr_word == W_TX_WP || wr_word == W_RX_RP) ? 2'b00 : 2'b10;
    assign rd_resp = (ar_word_q[10:8] == 3'b001 || (ar_word_q >= W_TX_WP && ar_word_q <= W_ID))
                     ? 2'b00 : 2'b10;
`else
    assign wr_resp = 2'b00;
    assign rd_resp = 2'b00;
`endif

    // TX dpram port is only driven during the write handshake cycle
    assign tx_wen_o   = wr_hs & wr_tx_win;
    assign tx_waddr_o = tx_wen_o ? S_AXI_AWADDR[9:2] : 8'd0;
    assign tx_wdata_o = tx_wen_o ? S_AXI_WDATA : 32'd0;

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign tx_wp_o       = tx_wp_q;
    assign rx_rp_o       = rx_rp_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            tx_wp_q    <= 8'd0;
            rx_rp_q    <= 8'd0;
        end else begin
            aw_ready_q <= !aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
                if (wr_word == W_TX_WP) tx_wp_q <= S_AXI_WDATA[7:0];
                if (wr_word == W_RX_RP) rx_rp_q <= S_AXI_WDATA[7:0];
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // The RX dpram samples the address on the AR handshake edge, so its data is ready in R_ADDR
    assign rx_raddr_o    = ar_hs ? S_AXI_ARADDR[9:2] : ar_word_q[7:0];
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RVALID  = rvalid_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state   <= R_IDLE;
            ar_ready_q <= 1'b0;
            ar_word_q  <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_ready_q <= 1'b0;
                        ar_word_q  <= S_AXI_ARADDR[12:2];
                        rd_state   <= R_ADDR;
                    end else begin
                        ar_ready_q <= S_AXI_ARVALID;
                    end
                end
                R_ADDR: begin
                    rdata_q  <= rd_mux(ar_word_q, rx_rdata_i, tx_wp_q, tx_rp_i, rx_wp_i, rx_rp_q);
                    rresp_q  <= rd_resp;
                    rvalid_q <= 1'b1;
                    rd_state <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_modem_axi_regs.sv
// Scoreboard bench for modem_axi_regs with a registered RX dpram model.
module tb_modem_axi_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [12:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [7:0]  rx_wp_i, tx_rp_i, rx_rp_o, tx_wp_o;
    logic [31:0] tx_wdata_o;
    logic [7:0]  tx_waddr_o;
    logic        tx_wen_o;
    logic [31:0] rx_rdata_i;
    logic [7:0]  rx_raddr_o;

    logic [31:0] rx_mem [256];
    logic [33:0] rd_sb [$];
    logic [1:0]  wr_sb [$];
    int n_vec = 0;
    int n_miscmp = 0;

`ifdef MODEM_AXI_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    always #5 clk = ~clk;

    always_ff @(posedge clk) rx_rdata_i <= rx_mem[rx_raddr_o];

    modem_axi_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .rx_wp_i(rx_wp_i), .tx_rp_i(tx_rp_i), .rx_rp_o(rx_rp_o), .tx_wp_o(tx_wp_o),
        .tx_wdata_o(tx_wdata_o), .tx_waddr_o(tx_waddr_o), .tx_wen_o(tx_wen_o),
        .rx_rdata_i(rx_rdata_i), .rx_raddr_o(rx_raddr_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [12:0] addr, input logic [31:0] data,
                             input bit exp_tx, input bit exp_ok, input int hold);
        int t;
        logic [1:0] eresp;
        wr_sb.push_back(exp_ok ? 2'b00 : ERR);
        @(posedge clk); #1;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!(awready && wready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!(awready && wready)) begin
            check("aw_timeout", 32'd0, 32'd1);
            void'(wr_sb.pop_back());
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check("tx_wen", 32'(tx_wen_o), 32'(exp_tx));
        if (exp_tx) begin
            check("tx_waddr", 32'(tx_waddr_o), 32'(addr[9:2]));
            check("tx_wdata", tx_wdata_o, data);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("tx_wen_pulse", 32'(tx_wen_o), 32'd0);
        check("bvalid_rise", 32'(bvalid), 32'd1);
        check("awready_drop", 32'(awready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bvalid), 32'd1);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        check("bvalid_acc", 32'(bvalid), 32'd1);
        eresp = wr_sb.pop_front();
        check("bresp", 32'(bresp), 32'(eresp));
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("bvalid_clr", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [12:0] addr, input logic [31:0] exp_data,
                            input bit exp_ok, input int hold);
        int t;
        logic [31:0] snap;
        logic [33:0] e;
        rd_sb.push_back({exp_ok ? 2'b00 : ERR, exp_data});
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!arready) begin
            check("ar_timeout", 32'd0, 32'd1);
            void'(rd_sb.pop_back());
            arvalid = 1'b0;
            return;
        end
        check("rx_raddr", 32'(rx_raddr_o), 32'(addr[9:2]));
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_early", 32'(rvalid), 32'd0);
        @(negedge clk);
        check("rvalid_lat", 32'(rvalid), 32'd1);
        snap = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, snap);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        e = rd_sb.pop_front();
        check("rdata", rdata, e[31:0]);
        check("rresp", 32'(rresp), 32'(e[33:32]));
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        check("rvalid_clr", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  idx;
        logic [31:0] v;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        rx_wp_i = 8'd0; tx_rp_i = 8'd0;
        for (int i = 0; i < 256; i++) rx_mem[i] = 32'h5A00_0000 + i;
        rx_mem[5] = 32'hCAFEBABE;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'({awready, wready, arready}), 32'd0);
        check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ptrs", 32'({tx_wp_o, rx_rp_o}), 32'd0);
        check("rst_dpram", 32'({tx_wen_o, rx_raddr_o}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        axi_read(13'h1010, 32'h4D4F4445, 1'b1, 0);
        axi_write(13'h0008, 32'hDEADBEEF, 1'b1, 1'b1, 0);
        axi_write(13'h1000, 32'h0000_01FF, 1'b0, 1'b1, 0);
        check("tx_wp_o", 32'(tx_wp_o), 32'h0000_00FF);
        axi_read(13'h1000, 32'h0000_00FF, 1'b1, 0);
        axi_write(13'h100C, 32'h0000_0012, 1'b0, 1'b1, 0);
        check("rx_rp_o", 32'(rx_rp_o), 32'h0000_0012);
        axi_read(13'h100C, 32'h0000_0012, 1'b1, 0);
        axi_read(13'h0414, 32'hCAFEBABE, 1'b1, 0);

        tx_rp_i = 8'h33; rx_wp_i = 8'h44;
        axi_read(13'h1004, 32'h0000_0033, 1'b1, 5);
        axi_read(13'h1008, 32'h0000_0044, 1'b1, 5);
        axi_write(13'h03FC, 32'h0123_4567, 1'b1, 1'b1, 5);

        axi_write(13'h1004, 32'h0000_00AA, 1'b0, 1'b0, 0);
        check("ro_tx_wp", 32'(tx_wp_o), 32'h0000_00FF);
        check("ro_rx_rp", 32'(rx_rp_o), 32'h0000_0012);
        axi_read(13'h1004, 32'h0000_0033, 1'b1, 0);
        axi_write(13'h0400, 32'h0000_0077, 1'b0, 1'b0, 0);
        axi_write(13'h1FFC, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        axi_read(13'h1FFC, 32'h0, 1'b0, 0);
        axi_read(13'h0000, 32'h0, 1'b0, 0);
        axi_read(13'h1014, 32'h0, 1'b0, 0);

        for (int k = 0; k < 4; k++) begin
            idx = 8'($urandom_range(0, 255));
            axi_read(13'h0400 + 13'({idx, 2'b00}), rx_mem[idx], 1'b1, k);
            v = $urandom;
            axi_write(13'h1000, v, 1'b0, 1'b1, 0);
            check("tx_wp_rand", 32'(tx_wp_o), 32'(v[7:0]));
            axi_read(13'h1000, {24'd0, v[7:0]}, 1'b1, 0);
        end

        // Reset asserted while a write response is pending
        @(posedge clk); #1;
        awaddr = 13'h100C; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_bvalid", 32'(bvalid), 32'd1);
        check("mid_rx_rp", 32'(rx_rp_o), 32'h55);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_ptr", 32'(rx_rp_o), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        axi_read(13'h1000, 32'h0, 1'b1, 0);
        axi_read(13'h100C, 32'h0, 1'b1, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
